// File: rtl/iic_pkg.sv
// iic_pkg -- shared types and constants for the IIC register sequencer.
//   state_t     : sequencer states (IDLE, ISSUE, SKIP, WAIT, CHECK, DONE)
//   byte_kind_t : which byte of the register transaction is current
//   RW_WRITE / RW_READ : encoding of req_rw
//   last_idx()  : index of the final byte for a given transfer direction
// Optional feature macro used by importers: IIC_SEQ_RETRY_EN.
package iic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        SKIP  = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        DEV_W = 3'd0,   // device address, write direction (start)
        REG   = 3'd1,   // register address
        WDATA = 3'd2,   // write payload (stop)
        DEV_R = 3'd3,   // device address, read direction (repeated start)
        RDATA = 3'd4    // received byte (master NACK + stop)
    } byte_kind_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Writes are three bytes long, reads are four.
    function automatic logic [1:0] last_idx(input logic rw);
        return (rw == RW_READ) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/iic_cmd_issue.sv
// iic_cmd_issue -- do/ready handshake toward the byte-level IIC controller.
// Given the current sequencer state it produces the cmd_do pulse and the
// next state for the ISSUE -> SKIP -> WAIT part of each byte.
//   state     in  : current sequencer state
//   cmd_ready in  : controller ready
//   cmd_do    out : one-cycle byte launch strobe
//   hs_next   out : next state while in ISSUE/SKIP/WAIT (else holds state)
// Handshake: a byte launches on the cycle cmd_do=1, which only happens in
// ISSUE while cmd_ready=1; completion is cmd_ready returning high in WAIT.
module iic_cmd_issue
    import iic_pkg::*;
(
    input  state_t state,
    input  logic   cmd_ready,
    output logic   cmd_do,
    output state_t hs_next
);

    always_comb begin
        cmd_do  = 1'b0;
        hs_next = state;
        case (state)
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_do  = 1'b1;
                    hs_next = SKIP;
                end
            end
            // The controller still shows the stale ready in the cycle after
            // do, so that cycle is skipped unconditionally.
            SKIP: hs_next = WAIT;
            WAIT: begin
                if (cmd_ready) begin
                    hs_next = CHECK;
                end
            end
            default: hs_next = state;
        endcase
    end

endmodule

// File: rtl/iic_reg_seq.sv
// iic_reg_seq -- register read/write sequencer on top of a byte-level IIC
// controller. A request is turned into a list of bytes (dev+W, reg, data for
// writes; dev+W, reg, dev+R, rx for reads) issued one at a time.
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_rw, req_dev, req_reg, req_wdata : request side
//   rsp_valid (1-cycle pulse), rsp_rdata, rsp_err            : response side
//   cmd_data_tx, cmd_start, cmd_stop, cmd_dir, cmd_do        : to controller
//   cmd_ready, cmd_error, cmd_data_rx                        : from controller
// Optional: define IIC_SEQ_RETRY_EN to retry address-byte NACKs up to
// RETRY_MAX extra times before reporting an error.
module iic_reg_seq
    import iic_pkg::*;
`ifdef IIC_SEQ_RETRY_EN
#(
    parameter int RETRY_MAX = 2
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] cmd_data_tx,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_dir,
    output logic       cmd_do,
    input  logic       cmd_ready,
    input  logic       cmd_error,
    input  logic [7:0] cmd_data_rx
);

    state_t     state, state_nx, hs_next;
    logic [1:0] idx, idx_nx;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q;
    logic       alive;          // low while in reset, keeps req_ready low
    logic       rsp_err_nx;
    logic [7:0] rsp_rdata_nx;
    logic       accept, active;
    byte_kind_t kind;
    logic [7:0] b_data;
    logic       b_start, b_stop, b_dir;

`ifdef IIC_SEQ_RETRY_EN
    localparam int CNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    logic [CNT_W-1:0] retry_cnt, retry_nx;
`endif

    assign req_ready = alive && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DONE);
    assign active    = (state == ISSUE) || (state == SKIP) ||
                       (state == WAIT)  || (state == CHECK);

    iic_cmd_issue u_issue (
        .state     (state),
        .cmd_ready (cmd_ready),
        .cmd_do    (cmd_do),
        .hs_next   (hs_next)
    );

    // Byte list: index selects the kind, kind selects the fields.
    always_comb begin
        case (idx)
            2'd0:    kind = DEV_W;
            2'd1:    kind = REG;
            2'd2:    kind = (rw_q == RW_READ) ? DEV_R : WDATA;
            default: kind = RDATA;
        endcase
    end

    always_comb begin
        b_data  = 8'h00;
        b_start = 1'b0;
        b_stop  = 1'b0;
        b_dir   = 1'b0;
        case (kind)
            DEV_W: begin b_data = {dev_q, 1'b0}; b_start = 1'b1; end
            REG:   begin b_data = reg_q; end
            WDATA: begin b_data = wdata_q; b_stop = 1'b1; end
            DEV_R: begin b_data = {dev_q, 1'b1}; b_start = 1'b1; end
            RDATA: begin b_dir = 1'b1; b_stop = 1'b1; end
            default: ;
        endcase
    end

    // Command fields are only meaningful while a byte is in flight.
    assign cmd_data_tx = active ? b_data  : 8'h00;
    assign cmd_start   = active && b_start;
    assign cmd_stop    = active && b_stop;
    assign cmd_dir     = active && b_dir;

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        rsp_err_nx   = rsp_err;
        rsp_rdata_nx = rsp_rdata;
`ifdef IIC_SEQ_RETRY_EN
        retry_nx     = retry_cnt;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ISSUE;
                    idx_nx   = 2'd0;
`ifdef IIC_SEQ_RETRY_EN
                    retry_nx = '0;
`endif
                end
            end
            ISSUE, SKIP, WAIT: state_nx = hs_next;
            CHECK: begin
                // Errors on the received byte are meaningless (we NACK it).
                if (cmd_error && !b_dir) begin
`ifdef IIC_SEQ_RETRY_EN
                    if (((kind == DEV_W) || (kind == DEV_R)) &&
                        (retry_cnt < CNT_W'(RETRY_MAX))) begin
                        retry_nx = retry_cnt + 1'b1;
                        idx_nx   = 2'd0;
                        state_nx = ISSUE;
                    end else begin
                        state_nx     = DONE;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = 8'h00;
                    end
`else
                    state_nx     = DONE;
                    rsp_err_nx   = 1'b1;
                    rsp_rdata_nx = 8'h00;
`endif
                end else if (idx == last_idx(rw_q)) begin
                    state_nx     = DONE;
                    rsp_err_nx   = 1'b0;
                    rsp_rdata_nx = (rw_q == RW_READ) ? cmd_data_rx : 8'h00;
                end else begin
                    idx_nx   = idx + 2'd1;
                    state_nx = ISSUE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            alive     <= 1'b0;
            rw_q      <= RW_WRITE;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
`ifdef IIC_SEQ_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            alive     <= 1'b1;
            state     <= state_nx;
            idx       <= idx_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rsp_rdata_nx;
`ifdef IIC_SEQ_RETRY_EN
            retry_cnt <= retry_nx;
`endif
            if (accept) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_iic_reg_seq.sv
// tb_iic_reg_seq -- self-checking bench for iic_reg_seq. A behavioural byte
// controller + slave answers cmd_do strobes; the expected byte stream and
// responses are derived per request from the transfer rules and checked by a
// monitor that pops them as the DUT presents bytes and responses.
module tb_iic_reg_seq;

`ifdef IIC_SEQ_RETRY_EN
    localparam int RETRY_MAX = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] cmd_data_tx;
    logic       cmd_start, cmd_stop, cmd_dir, cmd_do;
    logic       cmd_ready = 1'b1;
    logic       cmd_error = 1'b0;
    logic [7:0] cmd_data_rx = 8'h00;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

`ifdef IIC_SEQ_RETRY_EN
    iic_reg_seq #(.RETRY_MAX(RETRY_MAX)) dut (
`else
    iic_reg_seq dut (
`endif
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cmd_data_tx(cmd_data_tx), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_dir(cmd_dir), .cmd_do(cmd_do), .cmd_ready(cmd_ready),
        .cmd_error(cmd_error), .cmd_data_rx(cmd_data_rx)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [10:0] exp_byte_q[$];   // {start, stop, dir, data}
    logic [8:0]  exp_rsp_q[$];    // {err, rdata}

    // slave plan for the current request
    int         plan_id = 0;
    int         fault_k = -1;     // byte position NACKed, -1 = none
    bit         fault_persist = 1'b0;
    logic [7:0] plan_rx = 8'h00;
    int         stall_until = 0;  // controller holds ready low before this cycle

    int do_count = 0;
    int last_do_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- controller + slave model ----------------
    int         ctl_phase = 0;
    int         ctl_lat = 0;
    int         ctl_pos = 0;
    int         ctl_hits = 0;
    int         ctl_plan = -1;
    bit         ctl_do_now, ctl_dir_now, ctl_stop_now;
    bit         pend_err;
    logic [7:0] pend_rx;

    initial begin
        forever begin
            @(negedge clk);
            ctl_do_now   = cmd_do;
            ctl_dir_now  = cmd_dir;
            ctl_stop_now = cmd_stop;
            @(posedge clk);
            #1;
            if (rst) begin
                ctl_phase = 0;
                ctl_pos   = 0;
                cmd_ready = 1'b1;
                cmd_error = 1'b0;
            end else begin
                case (ctl_phase)
                    0: begin
                        if (ctl_do_now) begin
                            if (ctl_plan != plan_id) begin
                                ctl_plan = plan_id;
                                ctl_hits = 0;
                            end
                            if (ctl_dir_now) begin
                                pend_err = 1'($urandom_range(0, 1));
                                pend_rx  = plan_rx;
                                ctl_pos  = 0;
                            end else begin
                                pend_rx = 8'($urandom);
                                if (ctl_pos == fault_k && (fault_persist || ctl_hits == 0)) begin
                                    pend_err = 1'b1;
                                    ctl_hits++;
                                    ctl_pos = 0;
                                end else begin
                                    pend_err = 1'b0;
                                    ctl_pos  = ctl_stop_now ? 0 : ctl_pos + 1;
                                end
                            end
                            ctl_phase = 1;
                        end else begin
                            cmd_ready = (cyc >= stall_until);
                        end
                    end
                    1: begin
                        cmd_ready = 1'b0;
                        ctl_lat   = $urandom_range(0, 4);
                        ctl_phase = 2;
                    end
                    default: begin
                        if (ctl_lat == 0) begin
                            cmd_error   = pend_err;
                            cmd_data_rx = pend_rx;
                            cmd_ready   = 1'b1;
                            ctl_phase   = 0;
                        end else begin
                            ctl_lat--;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    bit          prev_do = 1'b0;
    bit          prev_rv = 1'b0;
    bit          busy = 1'b0;
    logic [8:0]  last_rsp = 9'h000;
    logic [10:0] eb;
    logic [8:0]  er;

    always @(negedge clk) begin
        if (rst) begin
            prev_do  = 1'b0;
            prev_rv  = 1'b0;
            busy     = 1'b0;
            last_rsp = 9'h000;
        end else begin
            if (cmd_do) begin
                do_count++;
                last_do_cyc = cyc;
                if (prev_do) fail_now("cmd_do_two_cycles", 1, 0);
                check("cmd_do_without_ready", cmd_ready, 1);
                if (exp_byte_q.size() == 0) begin
                    fail_now("unexpected_byte", int'(cmd_data_tx), -1);
                end else begin
                    eb = exp_byte_q.pop_front();
                    check("byte_start_stop_dir", {cmd_start, cmd_stop, cmd_dir}, eb[10:8]);
                    if (!eb[8]) check("byte_data", cmd_data_tx, eb[7:0]);
                end
            end
            if (rsp_valid) begin
                if (prev_rv) fail_now("rsp_valid_two_cycles", 1, 0);
                if (exp_rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp", int'({rsp_err, rsp_rdata}), -1);
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("rsp_err_rdata", {rsp_err, rsp_rdata}, er);
                end
                last_rsp = {rsp_err, rsp_rdata};
            end else begin
                check("rsp_hold", {rsp_err, rsp_rdata}, last_rsp);
            end
            if (busy) check("req_ready_while_busy", req_ready, 0);
            if (rsp_valid) busy = 1'b0;
            if (req_valid && req_ready) busy = 1'b1;
            prev_do = cmd_do;
            prev_rv = rsp_valid;
        end
    end

    // ---------------- driver ----------------
    int acc_cyc = 0;

    // Builds the expected byte stream / response from the transfer rules,
    // then presents the request until accepted.
    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input int fk, input bit persist,
                        input logic [7:0] rx, input bit hold);
        logic [10:0] l[$];
        bit retri;
        int attempts;
        int waited;
        l.push_back({3'b100, dev, 1'b0});
        l.push_back({3'b000, rg});
        if (rw) begin
            l.push_back({3'b100, dev, 1'b1});
            l.push_back({3'b011, 8'h00});
        end else begin
            l.push_back({3'b010, wd});
        end

        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!req_ready && waited < 3000);
        if (!req_ready) begin
            fail_now("req_ready_timeout", waited, 3000);
            return;
        end

        plan_id++;
        fault_k       = fk;
        fault_persist = persist;
        plan_rx       = rx;
        if (fk < 0) begin
            foreach (l[i]) exp_byte_q.push_back(l[i]);
            exp_rsp_q.push_back({1'b0, rw ? rx : 8'h00});
        end else begin
            retri = 1'b0;
`ifdef IIC_SEQ_RETRY_EN
            retri = (fk == 0) || (rw && fk == 2);
            attempts = (retri && persist) ? RETRY_MAX + 1 : 1;
`else
            attempts = 1;
`endif
            repeat (attempts) for (int i = 0; i <= fk; i++) exp_byte_q.push_back(l[i]);
            if (retri && !persist) begin
                foreach (l[i]) exp_byte_q.push_back(l[i]);
                exp_rsp_q.push_back({1'b0, rw ? rx : 8'h00});
            end else begin
                exp_rsp_q.push_back(9'h100);
            end
        end

        req_rw    = rw;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;
        // fields seen outside IDLE must be ignored
        req_rw    = 1'($urandom);
        req_dev   = 7'($urandom);
        req_reg   = 8'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((exp_byte_q.size() != 0 || exp_rsp_q.size() != 0 || !req_ready) && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 3000) fail_now("drain_timeout", waited, 3000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
        check({tag, "_cmd_ctl"}, {cmd_do, cmd_start, cmd_stop, cmd_dir}, 0);
        check({tag, "_cmd_data_tx"}, cmd_data_tx, 0);
    endtask

    // ---------------- main sequence ----------------
    int base;
    int fk;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", req_ready, 1);

        // directed write and read
        send(1'b0, 7'h50, 8'h12, 8'hA5, -1, 1'b0, 8'h00, 1'b0);
        send(1'b1, 7'h50, 8'h34, 8'h00, -1, 1'b0, 8'h5C, 1'b0);
        wait_drain();

        // address NACK: persistent and first-attempt-only
        base = do_count;
        send(1'b0, 7'h50, 8'h12, 8'hA5, 0, 1'b1, 8'h00, 1'b0);
        wait_drain();
`ifdef IIC_SEQ_RETRY_EN
        check("nack_addr_do_count", do_count - base, RETRY_MAX + 1);
`else
        check("nack_addr_do_count", do_count - base, 1);
`endif
        send(1'b1, 7'h50, 8'h34, 8'h00, 0, 1'b0, 8'h3C, 1'b0);
        send(1'b1, 7'h21, 8'h08, 8'h00, 2, 1'b1, 8'h11, 1'b0);
        send(1'b0, 7'h21, 8'h09, 8'h77, 2, 1'b1, 8'h00, 1'b0);
        wait_drain();

        // controller not ready at acceptance
        base = do_count;
        stall_until = cyc + 60;
        send(1'b0, 7'h3B, 8'hC0, 8'h0F, -1, 1'b0, 8'h00, 1'b0);
        wait_drain();
        check("stall_first_do_late", (last_do_cyc >= acc_cyc + 50), 1);
        check("stall_byte_count", do_count - base, 3);

        // randomized requests
        for (int i = 0; i < 40; i++) begin
            fk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
            send(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), fk,
                 1'($urandom), 8'($urandom), 1'b0);
        end
        wait_drain();

        // req_valid held high across back-to-back requests
        for (int i = 0; i < 8; i++) begin
            fk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
            send(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), fk,
                 1'($urandom), 8'($urandom), (i != 7));
        end
        wait_drain();

        // reset in the middle of a write (after the register byte launches)
        base = do_count;
        plan_id++;
        fault_k = -1;
        exp_byte_q.push_back({3'b100, 7'h2A, 1'b0});
        exp_byte_q.push_back({3'b000, 8'h77});
        @(posedge clk);
        #1;
        req_rw = 1'b0; req_dev = 7'h2A; req_reg = 8'h77; req_wdata = 8'hE1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int w = 0; w < 500 && do_count < base + 2; w++) @(posedge clk);
        check("reset_test_bytes_before", do_count - base, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midreset_no_leftover_bytes", exp_byte_q.size(), 0);
        @(posedge clk);
        #1;
        check("req_ready_after_midreset", req_ready, 1);
        send(1'b0, 7'h2A, 8'h77, 8'hE1, -1, 1'b0, 8'h00, 1'b0);
        send(1'b1, 7'h2A, 8'h78, 8'h00, -1, 1'b0, 8'h9D, 1'b0);
        wait_drain();

        repeat (5) @(posedge clk);
        check("final_byte_q_empty", exp_byte_q.size(), 0);
        check("final_rsp_q_empty", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iic_reg_seq.md
IIC_REG_SEQ -- requirements
Module: iic_reg_seq

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 2, meaning the number of extra attempts after an address-byte NACK (used only with IIC_SEQ_RETRY_EN).
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  register-access request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-006 SHALL have ports req_rw  input  1 (0 write, 1 read); req_dev  input  7  device address; req_reg  input  8  register address; req_wdata  input  8  write data.
REQ-007 SHALL have ports rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  8  read data; rsp_err  output  1  transaction failed.
REQ-008 SHALL have ports cmd_data_tx  output  8; cmd_start, cmd_stop, cmd_dir, cmd_do  output  1 each. These drive the byte-level IIC controller.
REQ-009 SHALL have ports cmd_ready  input  1; cmd_error  input  1; cmd_data_rx  input  8. These come from the byte-level IIC controller.

Function
REQ-010 SHALL use states IDLE, ISSUE, SKIP, WAIT, CHECK, DONE, with a byte index 0..3 selecting the current byte.
REQ-011 SHALL drive req_ready=1 only in IDLE; on acceptance, SHALL latch rw/dev/reg/wdata, set index=0, and go to ISSUE.
REQ-012 Write byte list: {dev,0} start=1 stop=0; reg start=0 stop=0; wdata start=0 stop=1. All have cmd_dir=0.
REQ-013 Read byte list: {dev,0} start=1; reg; {dev,1} start=1 (repeated start); rx byte dir=1 stop=1 (master NACK+STOP). The first three bytes have stop=0 and dir=0.
REQ-014 In ISSUE, SHALL hold cmd_data_tx/start/stop/dir stable and stay in ISSUE while cmd_ready=0.
REQ-015 When in ISSUE with cmd_ready=1, SHALL assert cmd_do for exactly one cycle and go to SKIP.
REQ-016 SKIP SHALL last exactly one cycle and ignore cmd_ready, because the controller drops ready one cycle after do.
REQ-017 WAIT SHALL hold until cmd_ready=1, then go to CHECK.
REQ-018 In CHECK, if cmd_error=1 on a dir=0 byte, SHALL abort to DONE with rsp_err=1; the controller has already issued STOP.
REQ-019 In CHECK with no error on a non-final byte, SHALL increment index and go to ISSUE. On the final byte it SHALL go to DONE, and for reads it SHALL latch cmd_data_rx into rsp_rdata.
REQ-020 DONE SHALL assert rsp_valid for one cycle, then return to IDLE. The earliest next acceptance is the cycle after DONE.
REQ-021 rsp_rdata SHALL be 0 on write completions and on errors; rsp_rdata/rsp_err SHALL hold until the next rsp_valid.
REQ-022 cmd_error SHALL be ignored after the dir=1 byte.
REQ-023 req_valid asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-024 On rst: state=IDLE, index=0, req_ready=0 during reset then 1, rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_do=0, cmd_start=0, cmd_stop=0, cmd_dir=0, cmd_data_tx=0.
REQ-025 Reset mid-transaction SHALL discard the transaction with no rsp_valid. The byte controller SHALL share rst.

Configuration
REQ-026 With macro IIC_SEQ_RETRY_EN defined: on a NACK of byte index 0 or of the repeated-start address, SHALL restart at index 0 up to RETRY_MAX times. rsp_err=1 SHALL be reported only after retries are exhausted, and the retry counter SHALL clear on acceptance.
REQ-027 Without IIC_SEQ_RETRY_EN, any NACK SHALL abort immediately, and RETRY_MAX and the retry counter SHALL be absent.

Structure
REQ-028 Package iic_pkg SHALL hold the state enum, the byte-kind constants (DEV_W, REG, WDATA, DEV_R, RDATA), and the RW_WRITE/RW_READ constants.
REQ-029 One sub-module, iic_cmd_issue, SHALL implement the ISSUE/SKIP/WAIT do-ready handshake. The top level SHALL hold the byte list and response logic.

Verification
REQ-030 Write dev=0x50 reg=0x12 data=0xA5 with an ACKing slave model -> bytes 0xA0(start), 0x12, 0xA5(stop); rsp_valid=1, rsp_err=0, rsp_rdata=0x00.
REQ-031 Read dev=0x50 reg=0x34, slave returns 0x5C -> bytes 0xA0(start), 0x34, 0xA1(start), rx(dir=1, stop=1); rsp_rdata=0x5C, rsp_err=0.
REQ-032 Slave NACKs 0xA0, macro off -> exactly one cmd_do pulse, then rsp_err=1. With the macro and RETRY_MAX=2 -> three 0xA0 attempts, then rsp_err=1.
REQ-033 cmd_ready held low 50 cycles at acceptance -> cmd_do stays low until cmd_ready=1. cmd_do is never high two consecutive cycles.
REQ-034 rst pulsed during byte 2 of a write -> all outputs at reset values, no rsp_valid; the next request completes normally.
REQ-035 req_valid held high continuously -> back-to-back transactions, with req_ready high only in IDLE and one rsp_valid per transaction.
